rr_grant_ctrl: RTL and testbench

Sequential round-robin grant controller wrapped around the combinational `arbiter` (one-hot `base`, `req`, `grant`). It owns the one-hot priority pointer that feeds the arbiter's `base`, registers the winning grant, holds it until the owner finishes, then rotates priority to the requester just past the winner. It sits directly upstream of the arbiter (producing `base`) and downstream of it (consuming `grant`), so the combinational arbiter becomes a fair, registered, hold-until-done arbiter for shared-resource access.

---
 rtl/rr_grant_ctrl.sv | 102 ++++++++++
 tb/tb_rr_grant_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered, hold-until-done grant around a combinational arbiter.
// Latency: 1 cycle request-to-grant, 1 cycle end-to-deassert; one idle cycle between grants.
// Backpressure: none; a grant is held until release, owner drop or MAX_HOLD expiry.

module arbiter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] grant
);
  logic [2*WIDTH-1:0] dbl_req;
  logic [2*WIDTH-1:0] dbl_gnt;

  // Borrow from base clears the first request at/above base; the upper copy handles wrap.
  assign dbl_req = {req, req};
  assign dbl_gnt = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
  assign grant   = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
endmodule

module rr_grant_ctrl #(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             release_grant,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] base,
  output logic             timeout
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] HOLD_LAST = 16'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state;
  logic [15:0]      hold_cnt;
  logic [WIDTH-1:0] cand;
  logic [IDX_W-1:0] cand_idx;
  logic             end_rel;
  logic             end_drop;
  logic             end_to;

  arbiter #(.WIDTH(WIDTH)) u_arbiter (
    .req   (req),
    .base  (base),
    .grant (cand)
  );

  always_comb begin
    cand_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i]) cand_idx = IDX_W'(i);
    end
  end

  assign end_rel  = release_grant;
  assign end_drop = ~|(req & grant);
  assign end_to   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      base        <= {{(WIDTH-1){1'b0}}, 1'b1};
      timeout     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= cand;
            grant_valid <= 1'b1;
            grant_idx   <= cand_idx;
            hold_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (end_rel || end_drop || end_to) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            base        <= {grant[WIDTH-2:0], grant[WIDTH-1]};
            timeout     <= end_to && !end_rel && !end_drop;
            state       <= IDLE;
          end else if (hold_cnt != 16'hFFFF) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl (WIDTH 16, MAX_HOLD 4): directed vector table plus a modelled random phase.
module tb_rr_grant_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        rel = 1'b0;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] base;
  logic        timeout;

  rr_grant_ctrl #(.WIDTH(16), .IDX_W(4), .MAX_HOLD(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .release_grant (rel),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .base          (base),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] grant;
    logic [3:0]  idx;
    logic [15:0] base;
    logic        to;
  } vec_t;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  idx;
    logic [15:0] base;
    logic        to;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   step   = 0;

  // Reference model state for the random phase
  logic [15:0] m_grant;
  logic [15:0] m_base;
  int          m_hold;
  logic        m_to;

  task automatic add(input logic r, input logic [15:0] rq, input logic rl,
                     input logic [15:0] g, input logic [3:0] ix, input logic [15:0] b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.rel = rl; v.grant = g; v.idx = ix; v.base = b; v.to = t;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [15:0] rq, input logic rl, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r; req = rq; rel = rl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("grant",       grant,               got.grant);
    check("grant_idx",   {12'd0, grant_idx},  {12'd0, got.idx});
    check("base",        base,                got.base);
    check("grant_valid", {15'd0, grant_valid}, {15'd0, |got.grant});
    check("timeout",     {15'd0, timeout},    {15'd0, got.to});
    step++;
  endtask

  function automatic logic [3:0] onehot_idx(input logic [15:0] v);
    logic [3:0] r = '0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [15:0] pick(input logic [15:0] rq, input logic [15:0] b);
    int          start = 0;
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) if (b[i]) start = i;
    for (int k = 0; k < 16; k++) begin
      int p = (start + k) % 16;
      if (rq[p] && r == 16'd0) r = 16'd1 << p;
    end
    return r;
  endfunction

  task automatic model_step(input logic r, input logic [15:0] rq, input logic rl);
    logic drop, tmo;
    if (r) begin
      m_grant = '0; m_base = 16'h0001; m_hold = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_grant == 16'd0) begin
        if (rq != 16'd0) begin
          m_grant = pick(rq, m_base);
          m_hold  = 0;
        end
      end else begin
        drop = (rq & m_grant) == 16'd0;
        tmo  = (m_hold == 3);
        if (rl || drop || tmo) begin
          m_base  = {m_grant[14:0], m_grant[15]};
          m_to    = tmo && !rl && !drop;
          m_grant = '0;
        end else if (m_hold < 65535) begin
          m_hold++;
        end
      end
    end
  endtask

  initial begin
    exp_t        e;
    logic [15:0] rq;
    logic        rl, r;

    // rst, req, rel  ->  grant, idx, base, timeout after the edge
    // Reset with all requests asserted, then first grant
    add(1, 16'hFFFF, 0, 16'h0000, 0, 16'h0001, 0);
    add(1, 16'hFFFF, 0, 16'h0000, 0, 16'h0001, 0);
    add(0, 16'hFFFF, 0, 16'h0001, 0, 16'h0001, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0);
    // Rotation, minimum-width grants, wrap of search
    add(0, 16'h0011, 0, 16'h0001, 0, 16'h0001, 0);
    add(0, 16'h0011, 1, 16'h0000, 0, 16'h0002, 0);
    add(0, 16'h0011, 0, 16'h0010, 4, 16'h0002, 0);
    add(0, 16'h0011, 1, 16'h0000, 0, 16'h0020, 0);
    add(0, 16'h0011, 0, 16'h0001, 0, 16'h0020, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0);
    // Top bit wraps base to bit 0
    add(0, 16'h8000, 0, 16'h8000, 15, 16'h0001, 0);
    add(0, 16'h8001, 1, 16'h0000, 0, 16'h0001, 0);
    add(0, 16'h8001, 0, 16'h0001, 0, 16'h0001, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0);
    // MAX_HOLD expiry, re-grant, then expiry coinciding with release and drop
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0001, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0001, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0001, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0001, 0);
    add(0, 16'h0004, 0, 16'h0000, 0, 16'h0008, 1);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0008, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0008, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0008, 0);
    add(0, 16'h0004, 0, 16'h0004, 2, 16'h0008, 0);
    add(0, 16'h0000, 1, 16'h0000, 0, 16'h0008, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0);
    // Other requesters change mid-grant, then owner drops
    add(0, 16'h0020, 0, 16'h0020, 5, 16'h0001, 0);
    add(0, 16'hFFFF, 0, 16'h0020, 5, 16'h0001, 0);
    add(0, 16'hFFDF, 0, 16'h0000, 0, 16'h0040, 0);
    add(0, 16'hFFDF, 0, 16'h0040, 6, 16'h0040, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0);
    // Mid-grant reset, then release while idle is ignored
    add(0, 16'h0100, 0, 16'h0100, 8, 16'h0001, 0);
    add(1, 16'h0100, 0, 16'h0000, 0, 16'h0001, 0);
    add(0, 16'h0100, 0, 16'h0100, 8, 16'h0001, 0);
    add(0, 16'h0100, 1, 16'h0000, 0, 16'h0200, 0);
    add(0, 16'h0000, 1, 16'h0000, 0, 16'h0200, 0);
    add(0, 16'h0100, 0, 16'h0100, 8, 16'h0200, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 16'h0200, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      e.grant = tbl[i].grant; e.idx = tbl[i].idx; e.base = tbl[i].base; e.to = tbl[i].to;
      apply(tbl[i].rst, tbl[i].req, tbl[i].rel, e);
    end

    // Random phase against the reference model, starting from reset
    model_step(1'b1, 16'h0000, 1'b0);
    e.grant = m_grant; e.idx = onehot_idx(m_grant); e.base = m_base; e.to = m_to;
    apply(1'b1, 16'h0000, 1'b0, e);
    rq = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) rq = 16'($urandom) & 16'($urandom);
      rl = ($urandom_range(4) == 0);
      r  = ($urandom_range(49) == 0);
      model_step(r, rq, rl);
      e.grant = m_grant; e.idx = onehot_idx(m_grant); e.base = m_base; e.to = m_to;
      apply(r, rq, rl, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
